// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_pkg
// Description : Shared constants for the CIC decimator run-control slice.
//               Holds the run-state encoding, the datapath widths and the
//               default smallest oversampling ratio.
// Revision    : 1.0 - initial release
// ============================================================================
package cic_pkg;

  // Run-state encoding, also exported on state_out
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_FLUSH  = 2'd1;
  localparam logic [1:0] c_ST_SETTLE = 2'd2;
  localparam logic [1:0] c_ST_RUN    = 2'd3;

  localparam int CIC_OUT_W   = 16;
  localparam int OSR_W       = 10;
  localparam int DEF_MIN_OSR = 4;

endpackage : cic_pkg
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : First-word-fall-through FIFO with synchronous clear.
//               A write is accepted when not full, or when full and a pop
//               happens in the same cycle. The head word is always on o_data.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_clr             - synchronous clear (empties the FIFO)
//               i_push, i_data    - write request and word
//               i_pop             - read request (ignored when empty)
//               o_data            - head word
//               o_empty, o_full   - status flags
//               o_level           - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_level   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still takes a word when the head leaves in the same cycle
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sample_fifo
`default_nettype wire

// File: rtl/cic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cic_ctrl
// Description : Run-control sequencer for a 3rd-order sinc/CIC decimator.
//               Latches and clamps the OSR, holds the filter in reset for a
//               flush period, discards the settling outputs and buffers the
//               valid samples in a FWFT FIFO behind a valid/ready port.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               start, stop, osr_in            - run commands, requested OSR
//               busy, state_out                - run status
//               cic_rst, cic_enable,
//               cic_oversample                 - decimator controls
//               cic_valid, cic_data            - decimator output
//               m_valid, m_ready, m_data       - sample stream
//               fifo_level, overflow,
//               sample_count                   - buffer status
// Revision    : 1.0 - initial release
// ============================================================================
module cic_ctrl
  import cic_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_SAMPLES = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int MIN_OSR        = DEF_MIN_OSR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic [OSR_W-1:0]              osr_in,
  output logic                          busy,
  output logic [1:0]                    state_out,
  output logic                          cic_rst,
  output logic                          cic_enable,
  output logic [OSR_W-1:0]              cic_oversample,
  input  logic                          cic_valid,
  input  logic [CIC_OUT_W-1:0]          cic_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CIC_OUT_W-1:0]          m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   sample_count
);

  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_SAMPLES + 2);

  // With no settling samples to discard the filter output is trusted at once
  localparam logic [1:0] c_AFTER_FLUSH = (SETTLE_SAMPLES == 0) ? c_ST_RUN : c_ST_SETTLE;

  logic [1:0]           r_state;
  logic [FL_W-1:0]      r_flush_cnt;
  logic [SET_W-1:0]     r_settle_cnt;
  logic                 r_cic_rst;
  logic                 r_cic_en;
  logic [OSR_W-1:0]     r_osr;
  logic                 r_overflow;
  logic [15:0]          r_sample_cnt;

  logic                 w_start_ok;
  logic                 w_stop_ok;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [OSR_W-1:0]     w_osr_clamped;

  // stop wins over start; start only counts in IDLE
  assign w_start_ok    = start & ~stop & (r_state == c_ST_IDLE);
  assign w_stop_ok     = stop & (r_state != c_ST_IDLE);
  // A sample arriving with stop in RUN is still kept
  assign w_push        = cic_valid & (r_state == c_ST_RUN);
  assign w_pop         = ~w_empty & m_ready;
  assign w_push_ok     = w_push & (~w_full | w_pop);
  assign w_drop        = w_push & w_full & ~w_pop;
  assign w_osr_clamped = (osr_in < OSR_W'(MIN_OSR)) ? OSR_W'(MIN_OSR) : osr_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_IDLE;
      r_flush_cnt  <= '0;
      r_settle_cnt <= '0;
      r_cic_rst    <= 1'b1;
      r_cic_en     <= 1'b0;
      r_osr        <= OSR_W'(MIN_OSR);
    end else if (w_stop_ok) begin
      r_state   <= c_ST_IDLE;
      r_cic_rst <= 1'b1;
      r_cic_en  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_cic_rst <= 1'b1;
          r_cic_en  <= 1'b0;
          if (w_start_ok) begin
            r_state     <= c_ST_FLUSH;
            r_osr       <= w_osr_clamped;
            r_flush_cnt <= FL_W'(FLUSH_CYCLES - 1);
          end
        end
        c_ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state      <= c_AFTER_FLUSH;
            r_settle_cnt <= '0;
            r_cic_rst    <= 1'b0;
            r_cic_en     <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        c_ST_SETTLE: begin
          if (cic_valid) begin
            if (r_settle_cnt == SET_W'(SETTLE_SAMPLES - 1)) begin
              r_state <= c_ST_RUN;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_cic_rst <= 1'b0;
          r_cic_en  <= 1'b1;
        end
      endcase
    end
  end

  // Buffer status survives a stop and is cleared only by a new start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_sample_cnt <= '0;
    end else if (w_start_ok) begin
      r_overflow   <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push_ok && (r_sample_cnt != 16'hFFFF)) begin
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
    end
  end

  sample_fifo #(
    .WIDTH (CIC_OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start_ok),
    .i_push  (w_push),
    .i_data  (cic_data),
    .i_pop   (m_ready),
    .o_data  (m_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  assign m_valid        = ~w_empty;
  assign busy           = (r_state != c_ST_IDLE);
  assign state_out      = r_state;
  assign cic_rst        = r_cic_rst;
  assign cic_enable     = r_cic_en;
  assign cic_oversample = r_osr;
  assign overflow       = r_overflow;
  assign sample_count   = r_sample_cnt;

endmodule : cic_ctrl
`default_nettype wire

// File: tb/tb_cic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_ctrl
// Description : Directed self-checking bench for cic_ctrl with default
//               parameters (FLUSH 4, SETTLE 3, FIFO depth 4, MIN_OSR 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [9:0]  osr_in;
  logic        busy;
  logic [1:0]  state_out;
  logic        cic_rst;
  logic        cic_enable;
  logic [9:0]  cic_oversample;
  logic        cic_valid;
  logic [15:0] cic_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] sample_count;

  int n_tests = 0;
  int n_fail  = 0;

  cic_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .osr_in         (osr_in),
    .busy           (busy),
    .state_out      (state_out),
    .cic_rst        (cic_rst),
    .cic_enable     (cic_enable),
    .cic_oversample (cic_oversample),
    .cic_valid      (cic_valid),
    .cic_data       (cic_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .sample_count   (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; osr_in = 10'd0;
    cic_valid = 1'b0; cic_data = 16'h0; m_ready = 1'b0;
    step(2);

    // ---- reset state
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cic_rst", 32'(cic_rst), 32'd1);
    check("rst_cic_en", 32'(cic_enable), 32'd0);
    check("rst_osr", 32'(cic_oversample), 32'd4);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_count", 32'(sample_count), 32'd0);
    rst_n = 1'b1;
    step();

    // ---- start with OSR 64: four FLUSH cycles, then SETTLE
    osr_in = 10'd64; start = 1'b1;
    step();
    start = 1'b0; osr_in = 10'd7;
    check("flush_state1", 32'(state_out), 32'd1);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_osr", 32'(cic_oversample), 32'd64);
    check("flush_cic_rst", 32'(cic_rst), 32'd1);
    step(3);
    check("flush_state4", 32'(state_out), 32'd1);
    check("flush_cic_rst4", 32'(cic_rst), 32'd1);
    step();
    check("settle_state", 32'(state_out), 32'd2);
    check("settle_cic_rst", 32'(cic_rst), 32'd0);
    check("settle_cic_en", 32'(cic_enable), 32'd1);

    // ---- three discarded settling samples
    cic_valid = 1'b1; cic_data = 16'hAAAA;
    step(2);
    check("settle_after2", 32'(state_out), 32'd2);
    step();
    check("run_state", 32'(state_out), 32'd3);
    check("settle_no_store", 32'(m_valid), 32'd0);
    cic_data = 16'h1234;
    step();
    cic_valid = 1'b0;
    check("first_m_valid", 32'(m_valid), 32'd1);
    check("first_m_data", 32'(m_data), 32'h1234);
    check("first_count", 32'(sample_count), 32'd1);
    check("first_level", 32'(fifo_level), 32'd1);

    // ---- start in RUN ignored
    osr_in = 10'd128; start = 1'b1;
    step();
    start = 1'b0;
    check("run_start_state", 32'(state_out), 32'd3);
    check("run_start_osr", 32'(cic_oversample), 32'd64);
    check("run_start_level", 32'(fifo_level), 32'd1);

    // ---- pop the first word
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("pop_level", 32'(fifo_level), 32'd0);
    check("pop_m_valid", 32'(m_valid), 32'd0);

    // ---- overflow: five pushes into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) begin
      cic_valid = 1'b1; cic_data = 16'(i);
      step();
    end
    cic_valid = 1'b0;
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(sample_count), 32'd5);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", 32'(m_data), 32'(i));
      step();
    end
    m_ready = 1'b0;
    check("drain_empty", 32'(m_valid), 32'd0);

    // ---- stop, restart with a small OSR (clamped)
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_state", 32'(state_out), 32'd0);
    check("stop_keeps_ovf", 32'(overflow), 32'd1);
    osr_in = 10'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("clamp_osr", 32'(cic_oversample), 32'd4);
    check("restart_ovf", 32'(overflow), 32'd0);
    check("restart_count", 32'(sample_count), 32'd0);
    step(4);
    cic_valid = 1'b1; cic_data = 16'h0;
    step(3);
    check("run2_state", 32'(state_out), 32'd3);

    // ---- fill, then push and pop together while full
    for (int i = 0; i < 4; i++) begin
      cic_data = 16'(16'h10 + i);
      step();
    end
    check("full_level", 32'(fifo_level), 32'd4);
    cic_data = 16'h14; m_ready = 1'b1;
    step();
    cic_valid = 1'b0;
    check("full_pp_level", 32'(fifo_level), 32'd4);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_count", 32'(sample_count), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      check("full_pp_order", 32'(m_data), 32'(16'h10 + i));
      step();
    end
    m_ready = 1'b0;
    check("full_pp_empty", 32'(fifo_level), 32'd0);

    // ---- stop coincident with a sample in RUN
    cic_valid = 1'b1; cic_data = 16'h0055;
    step();
    cic_data = 16'hBEEF; stop = 1'b1;
    step();
    cic_valid = 1'b0; stop = 1'b0;
    check("stopv_state", 32'(state_out), 32'd0);
    check("stopv_en", 32'(cic_enable), 32'd0);
    check("stopv_cic_rst", 32'(cic_rst), 32'd1);
    check("stopv_level", 32'(fifo_level), 32'd2);
    check("stopv_count", 32'(sample_count), 32'd7);
    cic_valid = 1'b1; cic_data = 16'h7777;
    step();
    cic_valid = 1'b0;
    check("idle_valid_ignored", 32'(fifo_level), 32'd2);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("idle_drain_level", 32'(fifo_level), 32'd1);
    check("idle_drain_data", 32'(m_data), 32'hBEEF);

    // ---- start and stop together in IDLE
    start = 1'b1; stop = 1'b1; osr_in = 10'd100;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_state", 32'(state_out), 32'd0);
    check("ss_level", 32'(fifo_level), 32'd1);
    check("ss_osr", 32'(cic_oversample), 32'd4);

    // ---- new start clears buffer status
    osr_in = 10'd64; start = 1'b1;
    step();
    start = 1'b0;
    check("clr_level", 32'(fifo_level), 32'd0);
    check("clr_m_valid", 32'(m_valid), 32'd0);
    check("clr_count", 32'(sample_count), 32'd0);
    check("clr_state", 32'(state_out), 32'd1);

    // ---- async reset in the middle of RUN
    step(4);
    cic_valid = 1'b1; cic_data = 16'h0;
    step(3);
    cic_data = 16'h4321;
    step();
    cic_valid = 1'b0;
    check("pre_rst_count", 32'(sample_count), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_out), 32'd0);
    check("arst_cic_rst", 32'(cic_rst), 32'd1);
    check("arst_en", 32'(cic_enable), 32'd0);
    check("arst_osr", 32'(cic_oversample), 32'd4);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_count", 32'(sample_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cic_ctrl
`default_nettype wire
